// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Serialises an instruction-fetch port and a data (load/store) port onto a
//   single-ported, variable-latency memory bus. One transaction is in flight
//   at a time: IDLE arbitrates, BUSY_I/BUSY_D hold m_req until m_ack (or a
//   timeout abort), RESP pulses the matching ack for one cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             fetch request (held until i_ack)
//   i_ack/i_rdata/i_err      fetch completion pulse, read data, timeout flag
//   d_req/d_we/d_be/d_addr/d_wdata
//                            data request (held until d_ack)
//   d_ack/d_rdata/d_err      data completion pulse, load data, timeout flag
//   m_req/m_we/m_be/m_addr/m_wdata
//                            memory bus request (all registered)
//   m_ack/m_rdata            memory completion strobe and read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,    // 1..15
   parameter int TIMEOUT    = 255   // 0 = never abort
) (
   input  logic                  clk,
   input  logic                  rst,
   // fetch port
   input  logic                  i_req,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic                  i_ack,
   output logic [DATA_W-1:0]     i_rdata,
   output logic                  i_err,
   // data port
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DATA_W/8-1:0]   d_be,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic                  d_ack,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  d_err,
   // memory port
   output logic                  m_req,
   output logic                  m_we,
   output logic [DATA_W/8-1:0]   m_be,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   input  logic                  m_ack,
   input  logic [DATA_W-1:0]     m_rdata
);

   localparam int BE_W = DATA_W / 8;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY_I = 2'd1;
   localparam logic [1:0] S_BUSY_D = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   // Last BUSY cycle index before an abort; unused when TIMEOUT is 0.
   localparam logic [7:0] TO_LAST    = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
   localparam bit         TO_EN      = (TIMEOUT != 0);

   logic [1:0]        r_state;
   logic [3:0]        r_starve;
   logic [7:0]        r_tmo;

   logic              r_m_req;
   logic              r_m_we;
   logic [BE_W-1:0]   r_m_be;
   logic [ADDR_W-1:0] r_m_addr;
   logic [DATA_W-1:0] r_m_wdata;

   logic              r_i_ack;
   logic              r_i_err;
   logic [DATA_W-1:0] r_i_rdata;
   logic              r_d_ack;
   logic              r_d_err;
   logic [DATA_W-1:0] r_d_rdata;

   logic w_idle;
   logic w_busy;
   logic w_busy_i;
   logic w_busy_d;
   logic w_grant_d;
   logic w_grant_i;
   logic w_abort;
   logic w_done;
   logic w_rd_done;

   // ------------------------------------------------------------------------
   // Arbitration and completion decode
   // ------------------------------------------------------------------------
   assign w_idle   = (r_state == S_IDLE);
   assign w_busy_i = (r_state == S_BUSY_I);
   assign w_busy_d = (r_state == S_BUSY_D);
   assign w_busy   = w_busy_i | w_busy_d;

   // Data has priority unless fetch has been passed over STARVE_MAX times.
   assign w_grant_d = w_idle & d_req & (~i_req | (r_starve != STARVE_LIM));
   assign w_grant_i = w_idle & i_req & ~w_grant_d;

   // Abort requires no m_ack this cycle, so an ack on the deadline wins.
   assign w_abort   = w_busy & ~m_ack & TO_EN & (r_tmo == TO_LAST);
   assign w_done    = w_busy & (m_ack | w_abort);
   assign w_rd_done = w_busy & m_ack & ~r_m_we;

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_d)      r_state <= S_BUSY_D;
               else if (w_grant_i) r_state <= S_BUSY_I;
            end
            S_BUSY_I, S_BUSY_D: begin
               if (w_done) r_state <= S_RESP;
            end
            default: r_state <= S_IDLE;   // S_RESP
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Memory bus: captured from the winner at grant, held through BUSY
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_req   <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_be    <= '0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
      end else if (w_grant_d) begin
         r_m_req   <= 1'b1;
         r_m_we    <= d_we;
         r_m_be    <= d_be;
         r_m_addr  <= d_addr;
         r_m_wdata <= d_wdata;
      end else if (w_grant_i) begin
         r_m_req   <= 1'b1;
         r_m_we    <= 1'b0;
         r_m_be    <= '1;
         r_m_addr  <= i_addr;
         r_m_wdata <= '0;
      end else if (w_done) begin
         r_m_req   <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Starvation counter: counts data grants that bypassed a waiting fetch
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve <= '0;
      end else if (w_grant_i) begin
         r_starve <= '0;
      end else if (w_grant_d) begin
         if (!i_req)
            r_starve <= '0;
         else if (r_starve != STARVE_LIM)
            r_starve <= r_starve + 4'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Timeout counter: zeroed at grant, counts BUSY cycles without m_ack
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo <= '0;
      end else if (w_grant_d | w_grant_i) begin
         r_tmo <= '0;
      end else if (w_busy & ~m_ack) begin
         r_tmo <= r_tmo + 8'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Responses: ack/err are high exactly during RESP; rdata only moves on a
   // completed read, so aborts and writes leave it untouched.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_i_ack   <= 1'b0;
         r_i_err   <= 1'b0;
         r_i_rdata <= '0;
         r_d_ack   <= 1'b0;
         r_d_err   <= 1'b0;
         r_d_rdata <= '0;
      end else begin
         r_i_ack <= w_done & w_busy_i;
         r_i_err <= w_abort & w_busy_i;
         r_d_ack <= w_done & w_busy_d;
         r_d_err <= w_abort & w_busy_d;
         if (w_rd_done & w_busy_i) r_i_rdata <= m_rdata;
         if (w_rd_done & w_busy_d) r_d_rdata <= m_rdata;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign m_req   = r_m_req;
   assign m_we    = r_m_we;
   assign m_be    = r_m_be;
   assign m_addr  = r_m_addr;
   assign m_wdata = r_m_wdata;

   assign i_ack   = r_i_ack;
   assign i_err   = r_i_err;
   assign i_rdata = r_i_rdata;
   assign d_ack   = r_d_ack;
   assign d_err   = r_d_err;
   assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (STARVE_MAX=4, TIMEOUT=8). Inputs change
// and outputs are checked 1 time unit after each rising edge.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we, m_ack;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [3:0]  d_be;
   logic        i_ack, i_err, d_ack, d_err;
   logic [31:0] i_rdata, d_rdata;
   logic        m_req, m_we;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata;

   int n_tests = 0;
   int n_fail  = 0;
   int i_ack_cnt = 0;
   int d_ack_cnt = 0;
   int both_cnt  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata)
   );

   // Ack pulse monitor
   always @(negedge clk) begin
      if (i_ack === 1'b1) i_ack_cnt++;
      if (d_ack === 1'b1) d_ack_cnt++;
      if (i_ack === 1'b1 && d_ack === 1'b1) both_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
      m_ack = 0; m_rdata = 0;
      tick(); tick();
      // reset state
      chk("rst_m_req",   32'(m_req), 0);
      chk("rst_m_be",    32'(m_be), 0);
      chk("rst_m_addr",  m_addr, 0);
      chk("rst_i_ack",   32'(i_ack), 0);
      chk("rst_d_ack",   32'(d_ack), 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      rst = 1'b0;
      tick();

      // 1. single fetch
      i_req = 1; i_addr = 32'h100;
      tick();
      chk("t1_m_req",  32'(m_req), 1);
      chk("t1_m_addr", m_addr, 32'h100);
      chk("t1_m_we",   32'(m_we), 0);
      chk("t1_m_be",   32'(m_be), 4'hF);
      chk("t1_i_ack_early", 32'(i_ack), 0);
      tick();
      m_ack = 1; m_rdata = 32'hDEADBEEF;
      tick();
      chk("t1_i_ack",   32'(i_ack), 1);
      chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
      chk("t1_i_err",   32'(i_err), 0);
      chk("t1_m_req_lo", 32'(m_req), 0);
      m_ack = 0; i_req = 0;
      tick();
      chk("t1_i_ack_pulse", 32'(i_ack), 0);
      chk("t1_no_d_ack", 32'(d_ack_cnt), 0);

      // 2. simultaneous fetch + store: data first
      i_req = 1; i_addr = 32'h104;
      d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h200; d_wdata = 32'h1234;
      tick();
      chk("t2_d_m_addr",  m_addr, 32'h200);
      chk("t2_d_m_we",    32'(m_we), 1);
      chk("t2_d_m_be",    32'(m_be), 4'h3);
      chk("t2_d_m_wdata", m_wdata, 32'h1234);
      m_ack = 1; m_rdata = 32'hBAD0BAD0;
      tick();
      chk("t2_d_ack",    32'(d_ack), 1);
      chk("t2_d_err",    32'(d_err), 0);
      chk("t2_i_ack_lo", 32'(i_ack), 0);
      chk("t2_d_rdata_hold", d_rdata, 0);
      chk("t2_i_rdata_hold", i_rdata, 32'hDEADBEEF);
      m_ack = 0; d_req = 0;
      tick();
      chk("t2_idle_m_req", 32'(m_req), 0);
      tick();
      chk("t2_i_m_req",  32'(m_req), 1);
      chk("t2_i_m_addr", m_addr, 32'h104);
      chk("t2_i_m_we",   32'(m_we), 0);
      chk("t2_i_m_be",   32'(m_be), 4'hF);
      m_ack = 1; m_rdata = 32'hCAFEF00D;
      tick();
      chk("t2_i_ack",   32'(i_ack), 1);
      chk("t2_i_rdata", i_rdata, 32'hCAFEF00D);
      m_ack = 0; i_req = 0;
      tick();

      // 3. starvation: 4 data grants, then fetch, then data again
      i_req = 1; i_addr = 32'h300;
      d_req = 1; d_we = 0; d_addr = 32'h400;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk($sformatf("t3_data_grant%0d", g), m_addr, 32'h400);
         m_ack = 1; m_rdata = 32'(g + 1);
         tick();
         chk($sformatf("t3_d_ack%0d", g), 32'(d_ack), 1);
         chk($sformatf("t3_d_rdata%0d", g), d_rdata, 32'(g + 1));
         m_ack = 0;
         tick();
      end
      tick();
      chk("t3_fetch_forced", m_addr, 32'h300);
      m_ack = 1; m_rdata = 32'h3333;
      tick();
      chk("t3_i_ack",   32'(i_ack), 1);
      chk("t3_i_rdata", i_rdata, 32'h3333);
      m_ack = 0;
      tick();
      tick();
      chk("t3_data_again", m_addr, 32'h400);
      m_ack = 1; m_rdata = 32'h55;
      tick();
      chk("t3_d_ack_again", 32'(d_ack), 1);
      m_ack = 0; d_req = 0; i_req = 0;
      tick();

      // 4. timeout: m_req high 8 cycles, then error ack
      d_req = 1; d_we = 0; d_addr = 32'h500;
      for (int c = 0; c < 8; c++) begin
         tick();
         chk($sformatf("t4_m_req_c%0d", c), 32'(m_req), 1);
      end
      tick();
      chk("t4_m_req_drop", 32'(m_req), 0);
      chk("t4_d_ack",      32'(d_ack), 1);
      chk("t4_d_err",      32'(d_err), 1);
      chk("t4_d_rdata",    d_rdata, 32'h55);
      d_req = 0;
      tick();
      chk("t4_d_ack_pulse", 32'(d_ack), 0);
      chk("t4_d_err_pulse", 32'(d_err), 0);
      tick(); tick();
      m_ack = 1; m_rdata = 32'h77;   // late ack
      tick();
      chk("t4_late_d_ack",  32'(d_ack), 0);
      chk("t4_late_i_ack",  32'(i_ack), 0);
      chk("t4_late_rdata",  d_rdata, 32'h55);
      chk("t4_late_m_req",  32'(m_req), 0);
      m_ack = 0;
      tick();

      // 5. ack in the final BUSY cycle wins over abort
      d_req = 1; d_we = 0; d_addr = 32'h600;
      tick();
      repeat (7) tick();
      chk("t5_m_req_last", 32'(m_req), 1);
      m_ack = 1; m_rdata = 32'h600D;
      tick();
      chk("t5_d_ack",   32'(d_ack), 1);
      chk("t5_d_err",   32'(d_err), 0);
      chk("t5_d_rdata", d_rdata, 32'h600D);
      m_ack = 0; d_req = 0;
      tick();

      // 6. reset during BUSY_I
      i_req = 1; i_addr = 32'h700;
      tick();
      chk("t6_busy", 32'(m_req), 1);
      rst = 1;
      tick();
      chk("t6_rst_m_req",  32'(m_req), 0);
      chk("t6_rst_i_ack",  32'(i_ack), 0);
      chk("t6_rst_d_ack",  32'(d_ack), 0);
      chk("t6_rst_i_rdata", i_rdata, 0);
      rst = 0;
      tick();
      chk("t6_regrant_m_req",  32'(m_req), 1);
      chk("t6_regrant_m_addr", m_addr, 32'h700);
      m_ack = 1; m_rdata = 32'h7777;
      tick();
      chk("t6_i_ack",   32'(i_ack), 1);
      chk("t6_i_rdata", i_rdata, 32'h7777);
      chk("t6_i_err",   32'(i_err), 0);
      m_ack = 0; i_req = 0;
      tick();
      tick();

      chk("total_i_acks", 32'(i_ack_cnt), 4);
      chk("total_d_acks", 32'(d_ack_cnt), 8);
      chk("ack_overlap",  32'(both_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
